// File: rtl/ws2812b_rx_decoder.sv
// ws2812b_rx_decoder: receive side of the WS2812B one-wire LED protocol.
// Oversamples din at clk, classifies each high pulse by width, captures the
// first 24 bits (GRB, MSB first) and detects the RET gap that ends a frame.
// Optional macro WS2812B_DOUT_FWD_EN: forwards bits 25+ on dout so decoders
// can be chained; when undefined dout is tied low.
module ws2812b_rx_decoder #(
    parameter int THRESH_CYCLES   = 60,
    parameter int MIN_HIGH_CYCLES = 20,
    parameter int MAX_HIGH_CYCLES = 110,
    parameter int RET_CYCLES      = 5000,
    parameter int CNT_W           = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic        bit_error,
    output logic [15:0] fwd_count,
    output logic        dout
);

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, ERR_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESH_CYCLES);
    localparam logic [CNT_W-1:0] MAXM1_C = CNT_W'(MAX_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETM1_C = CNT_W'(RET_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_idx;
    logic [22:0]      shift_reg;
    logic             frame_bad;
    logic             din_meta;
    logic             din_s;
    logic             din_s_d;

    logic             rise;
    logic             fall;
    logic             rec_bit;
    logic             capture;
    logic             last_bit;
    logic             ret_hit;
    logic             bit_val;
    logic [23:0]      shift_next;

    // Forward counter saturates instead of wrapping on very long chains
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rise       = din_s & ~din_s_d;
    assign fall       = ~din_s & din_s_d;
    // A high that ends at or above the glitch limit is a real bit
    assign rec_bit    = (state == MEAS_HIGH) && fall && (cnt >= MIN_C);
    assign capture    = rec_bit && (bit_idx < 5'd24);
    assign last_bit   = capture && (bit_idx == 5'd23);
    // Rising edge wins over the gap count reaching its limit
    assign ret_hit    = (state == MEAS_LOW) && !rise && (cnt >= RETM1_C);
    assign bit_val    = (cnt >= THR_C);
    assign shift_next = {shift_reg, bit_val};

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_s_d  <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            din_s_d  <= din_s;
        end
    end

    // Pulse/gap measurement FSM with registered event outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            frame_bad   <= 1'b0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            fwd_count   <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEAS_HIGH;
                        cnt       <= CNT_ONE;
                        fwd_count <= '0;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state <= MEAS_LOW;
                        cnt   <= CNT_ONE;
                        if (!rec_bit) begin
                            bit_error <= 1'b1;
                            frame_bad <= 1'b1;
                        end else if (capture) begin
                            shift_reg <= shift_next[22:0];
                            bit_idx   <= bit_idx + 5'd1;
                            if (last_bit && !frame_bad) begin
                                pixel_data  <= shift_next;
                                pixel_valid <= 1'b1;
                            end
                        end else begin
                            fwd_count <= sat_inc16(fwd_count);
                        end
                    end else if (cnt == MAXM1_C) begin
                        state     <= ERR_HIGH;
                        cnt       <= cnt + CNT_ONE;
                        bit_error <= 1'b1;
                        frame_bad <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ERR_HIGH: begin
                    if (fall) begin
                        state <= MEAS_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        state <= MEAS_HIGH;
                        cnt   <= CNT_ONE;
                    end else if (ret_hit) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        frame_bad  <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WS2812B_DOUT_FWD_EN
    logic fwd_gate;

    // Gate opens after the own pixel is consumed and closes at frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_gate <= 1'b0;
            dout     <= 1'b0;
        end else begin
            if (ret_hit) begin
                fwd_gate <= 1'b0;
            end else if (last_bit) begin
                fwd_gate <= 1'b1;
            end
            dout <= din_s & fwd_gate;
        end
    end
`else
    assign dout = 1'b0;
`endif

endmodule
